if_stage_reg_elastic: RTL and testbench

- Parametrised IF→ID pipeline register; successor to the fixed 32-bit free-running IF stage register.
- Adds a valid/ready handshake and a 2-entry skid buffer, so fetch never loses an instruction when decode stalls.
- Adds a synchronous flush for branch redirect, a configurable bubble instruction, and a saturating stall counter for performance monitoring.
- Sits between the fetch unit (PC + instruction memory) and the ID stage.

---
 rtl/if_stage_reg_elastic_if.sv | 25 ++
 rtl/if_stage_reg_elastic.sv | 107 ++++++++++
 tb/tb_if_stage_reg_elastic.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_reg_elastic_if.sv
// IF->ID handshake bundle: fetch-side and decode-side valid/ready pairs.
// The master is the fetch/decode environment, the slave is the pipeline register.
interface if_stage_reg_elastic_if #(
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [PC_WIDTH-1:0]   PC_in;
   logic [INST_WIDTH-1:0] Instruction_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [PC_WIDTH-1:0]   PC;
   logic [INST_WIDTH-1:0] Instruction;

   modport master (
      output in_valid, PC_in, Instruction_in, out_ready,
      input  in_ready, out_valid, PC, Instruction
   );

   modport slave (
      input  in_valid, PC_in, Instruction_in, out_ready,
      output in_ready, out_valid, PC, Instruction
   );
endinterface

// File: rtl/if_stage_reg_elastic.sv
// Elastic IF->ID register: main entry plus one skid entry, flush to bubble,
// and a saturating decode-stall counter.
module if_stage_reg_elastic #(
   parameter int                    PC_WIDTH        = 32,
   parameter int                    INST_WIDTH      = 32,
   parameter logic [INST_WIDTH-1:0] NOP_INST        = '0,
   parameter int                    STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   if_stage_reg_elastic_if.slave      bus,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] FULL  = 2'd1;
   localparam logic [1:0] SKID  = 2'd2;

   localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE =
      {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]            state;
   logic                  out_valid_q;
   logic                  in_ready_q;
   logic                  skid_full;
   logic [PC_WIDTH-1:0]   pc_q;
   logic [INST_WIDTH-1:0] inst_q;
   logic [PC_WIDTH-1:0]   skid_pc;
   logic [INST_WIDTH-1:0] skid_inst;
   logic                  in_fire;
   logic                  out_fire;

   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.PC          = pc_q;
   assign bus.Instruction = inst_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         skid_full   <= 1'b0;
         pc_q        <= '0;
         inst_q      <= NOP_INST;
         skid_pc     <= '0;
         skid_inst   <= NOP_INST;
         stall_count <= '0;
      end else if (flush) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         skid_full   <= 1'b0;
         pc_q        <= '0;
         inst_q      <= NOP_INST;
      end else begin
         if (out_valid_q & ~bus.out_ready & ~&stall_count)
            stall_count <= stall_count + CNT_ONE;
         unique case (1'b1)
            state == EMPTY: begin
               if (in_fire) begin
                  state       <= FULL;
                  out_valid_q <= 1'b1;
                  pc_q        <= bus.PC_in;
                  inst_q      <= bus.Instruction_in;
               end
            end
            state == FULL: begin
               if (in_fire & bus.out_ready) begin
                  pc_q   <= bus.PC_in;
                  inst_q <= bus.Instruction_in;
               end else if (in_fire) begin
                  // decode stalled: park the new entry, stop fetch next cycle
                  state      <= SKID;
                  skid_pc    <= bus.PC_in;
                  skid_inst  <= bus.Instruction_in;
                  skid_full  <= 1'b1;
                  in_ready_q <= 1'b0;
               end else if (out_fire) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            state == SKID: begin
               if (out_fire) begin
                  state      <= FULL;
                  pc_q       <= skid_pc;
                  inst_q     <= skid_inst;
                  skid_full  <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               skid_full   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage_reg_elastic.sv
// Directed and randomized scoreboard bench for the elastic IF->ID register.
module tb_if_stage_reg_elastic;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] stall_count;
   logic [3:0]  stall_count_s;

   int n_chk  = 0;
   int n_pass = 0;

   logic [63:0] q[$];
   logic [63:0] e;

   always #5 clk = ~clk;

   if_stage_reg_elastic_if #(.PC_WIDTH(32), .INST_WIDTH(32)) b ();
   if_stage_reg_elastic_if #(.PC_WIDTH(32), .INST_WIDTH(32)) b2 ();

   if_stage_reg_elastic #(
      .PC_WIDTH(32), .INST_WIDTH(32),
      .NOP_INST(NOP), .STALL_CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .bus(b.slave), .stall_count(stall_count)
   );

   if_stage_reg_elastic #(
      .PC_WIDTH(32), .INST_WIDTH(32),
      .NOP_INST(32'h0), .STALL_CNT_WIDTH(4)
   ) dut_s (
      .clk(clk), .rst(rst), .flush(flush),
      .bus(b2.slave), .stall_count(stall_count_s)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc,
                        input logic [31:0] inst, input logic rdy);
      b.in_valid       = v;
      b.PC_in          = pc;
      b.Instruction_in = inst;
      b.out_ready      = rdy;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b1, 32'h40, 32'h123, 1'b1);
      b2.in_valid = 1'b0;
      b2.PC_in = 32'h0;
      b2.Instruction_in = 32'h0;
      b2.out_ready = 1'b1;
      #1;
      tick;
      tick;
      chk("rst_ov", b.out_valid, 0);
      chk("rst_pc", b.PC, 0);
      chk("rst_inst", b.Instruction, NOP);
      chk("rst_ir", b.in_ready, 1);
      chk("rst_cnt", stall_count, 0);

      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'(i * 4), 32'hE000_0001 + 32'(i), 1'b1);
         tick;
         chk("flow_ov", b.out_valid, 1);
         chk("flow_pc", b.PC, 64'(i * 4));
         chk("flow_inst", b.Instruction, 64'(32'hE000_0001 + 32'(i)));
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick;
      chk("drain_ov", b.out_valid, 0);
      chk("drain_pc", b.PC, 32'h8);

      drive(1'b1, 32'h4, 32'hE000_0002, 1'b1);
      tick;
      drive(1'b1, 32'h8, 32'hE000_0003, 1'b0);
      tick;
      chk("skid_ir", b.in_ready, 0);
      chk("skid_pc", b.PC, 32'h4);
      chk("skid_ov", b.out_valid, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick;
      chk("skid_pc2", b.PC, 32'h8);
      chk("skid_inst2", b.Instruction, 32'hE000_0003);
      chk("skid_ir2", b.in_ready, 1);
      tick;
      chk("skid_empty", b.out_valid, 0);
      chk("skid_cnt", stall_count, 1);

      drive(1'b1, 32'h10, 32'hE000_0010, 1'b0);
      tick;
      drive(1'b1, 32'h14, 32'hE000_0014, 1'b0);
      tick;
      chk("fl_pre_ir", b.in_ready, 0);
      chk("fl_pre_pc", b.PC, 32'h10);
      flush = 1'b1;
      drive(1'b1, 32'h18, 32'hE000_0018, 1'b0);
      tick;
      flush = 1'b0;
      chk("fl_ov", b.out_valid, 0);
      chk("fl_inst", b.Instruction, NOP);
      chk("fl_pc", b.PC, 0);
      chk("fl_ir", b.in_ready, 1);
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      tick;
      tick;
      chk("fl_nodeliver", b.out_valid, 0);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      drive(1'b1, 32'h20, 32'hE000_0020, 1'b0);
      tick;
      b.in_valid = 1'b0;
      repeat (5) tick;
      chk("pri_cnt5", stall_count, 5);
      rst = 1'b1;
      flush = 1'b1;
      tick;
      rst = 1'b0;
      flush = 1'b0;
      chk("pri_rst_cnt", stall_count, 0);
      chk("pri_rst_ov", b.out_valid, 0);
      b.in_valid = 1'b1;
      tick;
      b.in_valid = 1'b0;
      repeat (5) tick;
      flush = 1'b1;
      b.out_ready = 1'b1;
      tick;
      flush = 1'b0;
      chk("pri_fl_cnt", stall_count, 5);
      chk("pri_fl_ov", b.out_valid, 0);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      b2.in_valid = 1'b1;
      b2.PC_in = 32'h44;
      b2.out_ready = 1'b0;
      tick;
      b2.in_valid = 1'b0;
      repeat (14) tick;
      chk("sat_14", stall_count_s, 14);
      tick;
      chk("sat_15", stall_count_s, 15);
      repeat (5) tick;
      chk("sat_hold", stall_count_s, 15);
      chk("sat_pc", b2.PC, 32'h44);

      rst = 1'b1;
      tick;
      rst = 1'b0;
      q.delete();
      for (int i = 0; i < 10000; i++) begin
         b.in_valid       = ($urandom_range(99) < 60);
         b.out_ready      = ($urandom_range(99) < 60);
         flush            = ($urandom_range(99) == 0);
         b.PC_in          = $urandom;
         b.Instruction_in = $urandom;
         #1;
         chk("rnd_ov", b.out_valid, 64'(q.size() != 0));
         chk("rnd_ir", b.in_ready, 64'(q.size() < 2));
         if (flush) begin
            q.delete();
         end else begin
            if (b.out_valid && b.out_ready) begin
               if (q.size() == 0) begin
                  chk("rnd_underflow", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("rnd_pc", b.PC, 64'(e[63:32]));
                  chk("rnd_inst", b.Instruction, 64'(e[31:0]));
               end
            end
            if (b.in_valid && b.in_ready)
               q.push_back({b.PC_in, b.Instruction_in});
         end
         tick;
      end
      flush = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
